// File: rtl/score_keeper_if.sv
// score_keeper_if: event flags from the game engine and score/lives/phase back to the display
interface score_keeper_if #(parameter int DIGITS = 4);
  logic start, enemy_killed, player_hit;
  logic [4*DIGITS-1:0] score_bcd, hiscore_bcd;
  logic [3:0] lives;
  logic playing, game_over, score_tick;
  modport master(output start, enemy_killed, player_hit,
                 input score_bcd, hiscore_bcd, lives, playing, game_over, score_tick);
  modport slave(input start, enemy_killed, player_hit,
                output score_bcd, hiscore_bcd, lives, playing, game_over, score_tick);
endinterface

// File: rtl/score_keeper.sv
// score_keeper: edge-detected kill/hit/start events drive BCD score, high score, lives and game phase
module score_keeper #(
  parameter int DIGITS = 4,
  parameter int START_LIVES = 3,
  parameter int KILL_PTS = 1
) (
  input logic clk,
  input logic reset,
  score_keeper_if.slave sk
);
  localparam int W = 4*DIGITS;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t state_q, state_d;
  logic [W-1:0] score_q, score_d, hi_q, hi_d, sum, inc;
  logic [3:0] lives_q, lives_d;
  logic start_q, kill_q, hit_q, tick_q, carry;
  logic start_e, kill_e, hit_e;
  function automatic logic [W:0] bcd_add(input logic [W-1:0] v);
    logic [4:0] d;
    logic c;
    logic [W-1:0] r;
    c = 1'b0;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, v[4*i+:4]} + 5'(c) + (i == 0 ? 5'(KILL_PTS) : 5'd0);
      c = d > 5'd9;
      r[4*i+:4] = c ? 4'(d - 5'd10) : d[3:0];
    end
    return {c, r};
  endfunction
  assign start_e = sk.start & ~start_q;
  assign kill_e = sk.enemy_killed & ~kill_q;
  assign hit_e = sk.player_hit & ~hit_q;
  assign {carry, sum} = bcd_add(score_q);
  assign inc = carry ? {DIGITS{4'h9}} : sum;
  // high score captures the post-kill score when the last life goes in the same update
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    hi_d = hi_q;
    lives_d = lives_q;
    if (state_q == PLAY) begin
      if (kill_e) score_d = inc;
      if (hit_e) lives_d = lives_q - 4'd1;
      if (hit_e && lives_q == 4'd1) begin
        state_d = OVER;
        hi_d = score_d > hi_q ? score_d : hi_q;
      end
    end else if (start_e) begin
      state_d = PLAY;
      score_d = '0;
      lives_d = 4'(START_LIVES);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      hi_q <= '0;
      lives_q <= 4'(START_LIVES);
      tick_q <= 1'b0;
      start_q <= 1'b0;
      kill_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hi_q <= hi_d;
      lives_q <= lives_d;
      tick_q <= score_d != score_q;
      start_q <= sk.start;
      kill_q <= sk.enemy_killed;
      hit_q <= sk.player_hit;
    end
  end
  assign sk.score_bcd = score_q;
  assign sk.hiscore_bcd = hi_q;
  assign sk.lives = lives_q;
  assign sk.playing = state_q == PLAY;
  assign sk.game_over = state_q == OVER;
  assign sk.score_tick = tick_q;
endmodule
